// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its writeback stage: opcodes, CC bit positions,
// writeback FSM encoding and default datapath geometry.
package alu_pkg;

   localparam int ALU_WIDTH = 16;
   localparam int ALU_NREGS = 8;
   localparam int ALU_AW    = 3;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;

   localparam int CC_ZERO = 0;
   localparam int CC_NEG  = 1;
   localparam int CC_POS  = 2;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_WR_HI = 1'b1
   } wb_state_e;

   // Every opcode with the top bit set is outside the ALU's instruction set.
   function automatic logic op_is_legal(input logic [3:0] op);
      return ~op[3];
   endfunction

endpackage

// File: rtl/wb_regfile.sv
// Register file for the writeback stage: one synchronous write port, two combinational
// read ports, R0 reads as zero and ignores writes.
module wb_regfile
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int NREGS = ALU_NREGS,
   parameter int AW    = ALU_AW
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    ra_addr_i,
   output logic [WIDTH-1:0] ra_data_o,
   input  logic [AW-1:0]    rb_addr_i,
   output logic [WIDTH-1:0] rb_data_o
);

   logic [WIDTH-1:0] mem_q [NREGS];

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // No bypass: a read during a write to the same register sees the old contents.
   assign ra_data_o = (ra_addr_i == '0) ? '0 : mem_q[ra_addr_i];
   assign rb_data_o = (rb_addr_i == '0) ? '0 : mem_q[rb_addr_i];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage of the 16-bit ALU: commits results to the register file, keeps CC and
// the sticky overflow flag, and splits MUL products into two consecutive register writes.
module alu_writeback
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int NREGS = ALU_NREGS,
   parameter int AW    = ALU_AW
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [3:0]       IN_OP,
   input  logic [AW-1:0]    IN_DEST,
   input  logic [WIDTH-1:0] IN_Z,
   input  logic [WIDTH-1:0] IN_OF,
   input  logic [2:0]       IN_CC,
   input  logic [AW-1:0]    RD_A_ADDR,
   output logic [WIDTH-1:0] RD_A_DATA,
   input  logic [AW-1:0]    RD_B_ADDR,
   output logic [WIDTH-1:0] RD_B_DATA,
   input  logic             CLR_STICKY,
   output logic [2:0]       CC_REG,
   output logic             STICKY_OVF,
   output logic             ILLEGAL,
   output logic             WB_DONE
);

   wb_state_e        state_q;
   logic [WIDTH-1:0] hold_hi_q;
   logic [AW-1:0]    hold_dest_q;
   logic [2:0]       cc_q;
   logic             sticky_q;
   logic             illegal_q;
   logic             done_q;

   logic             accept;
   logic             legal;
   logic             is_mul;
   logic             commit_lo;
   logic             sticky_d;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;

   assign IN_READY  = (state_q == WB_IDLE);
   assign accept    = IN_VALID & IN_READY;
   assign legal     = op_is_legal(IN_OP);
   assign is_mul    = (IN_OP == OP_MUL);
   assign commit_lo = accept & legal;

   // Set has priority over clear; MUL's high word is not an overflow indication.
   assign sticky_d  = (commit_lo & ~is_mul & (IN_OF != '0)) | (sticky_q & ~CLR_STICKY);

   assign we    = commit_lo | (state_q == WB_WR_HI);
   assign waddr = (state_q == WB_WR_HI) ? hold_dest_q : IN_DEST;
   assign wdata = (state_q == WB_WR_HI) ? hold_hi_q   : IN_Z;

   wb_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk_i     (CLK),
      .srst_i    (RESET),
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .ra_addr_i (RD_A_ADDR),
      .ra_data_o (RD_A_DATA),
      .rb_addr_i (RD_B_ADDR),
      .rb_data_o (RD_B_DATA)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= WB_IDLE;
         hold_hi_q   <= '0;
         hold_dest_q <= '0;
         cc_q        <= '0;
         sticky_q    <= 1'b0;
         illegal_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         sticky_q  <= sticky_d;
         illegal_q <= accept & ~legal;
         done_q    <= 1'b0;
         case (state_q)
            WB_IDLE: begin
               if (commit_lo) begin
                  cc_q <= IN_CC;
                  if (is_mul) begin
                     hold_hi_q   <= IN_OF;
                     hold_dest_q <= IN_DEST + AW'(1);
                     state_q     <= WB_WR_HI;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            WB_WR_HI: begin
               state_q <= WB_IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= WB_IDLE;
         endcase
      end
   end

   assign CC_REG     = cc_q;
   assign STICKY_OVF = sticky_q;
   assign ILLEGAL    = illegal_q;
   assign WB_DONE    = done_q;

endmodule
